syn_fifo_flags: RTL

Single-clock, parametrised FIFO: the same-clock counterpart of the team's dual-clock FIFO. It adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It sits between same-domain producer/consumer stages where no clock crossing, and hence no Gray-code synchronisation, is needed.

---
 rtl/syn_fifo_pkg.sv | 22 ++
 rtl/syn_fifo_mem.sv | 34 +++
 rtl/syn_fifo_flags.sv | 133 +++++++++++++
 3 files changed

// File: rtl/syn_fifo_pkg.sv
// Shared types, default thresholds and parameter sanity check for the
// single-clock flagged FIFO.
package syn_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int unsigned DEF_AFULL_MARGIN  = 2;
    localparam int unsigned DEF_AEMPTY_THRESH = 2;

    // True when depth is a power of two >= 2 and both thresholds are reachable.
    function automatic bit params_ok(input int unsigned len,
                                     input int unsigned addr_bits,
                                     input int unsigned afull,
                                     input int unsigned aempty);
        return (len >= 2) && ((len & (len - 1)) == 0) && (addr_bits == $clog2(len)) &&
               (afull >= 1) && (afull <= len) && (aempty <= len - 1);
    endfunction

endpackage

// File: rtl/syn_fifo_mem.sv
// FIFO storage: register array with a synchronous write port and an
// asynchronous read port.
module syn_fifo_mem
    import syn_fifo_pkg::*;
#(
    parameter int unsigned DataBits = 10,
    parameter int unsigned Depth    = 16,
    parameter int unsigned AddrBits = $clog2(Depth)
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [AddrBits-1:0] waddr_i,
    input  logic [DataBits-1:0] wdata_i,
    input  logic [AddrBits-1:0] raddr_i,
    output logic [DataBits-1:0] rdata_o
);

    logic [DataBits-1:0] mem_q [Depth];
    logic [DataBits-1:0] mem_d [Depth];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/syn_fifo_flags.sv
// Single-clock FIFO with occupancy level, almost-full/empty thresholds,
// sticky overflow/underflow flags and optional first-word-fall-through reads.
module syn_fifo_flags
    import syn_fifo_pkg::*;
#(
    parameter int unsigned DATA_BITS     = 10,
    parameter int unsigned FIFO_LENGTH   = 16,
    parameter int unsigned ADDR_BIT      = $clog2(FIFO_LENGTH),
    parameter int unsigned FWFT          = 0,
    parameter int unsigned AFULL_THRESH  = FIFO_LENGTH - DEF_AFULL_MARGIN,
    parameter int unsigned AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic [DATA_BITS-1:0] input_data,
    input  logic                 read,
    output logic [DATA_BITS-1:0] output_data,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_BIT:0]    level,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 clear_err
);

    localparam int unsigned LvlW = ADDR_BIT + 1;
    localparam fifo_mode_e Mode = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [ADDR_BIT:0] FullLvl   = LvlW'(FIFO_LENGTH);
    localparam logic [ADDR_BIT:0] AfullLvl  = LvlW'(AFULL_THRESH);
    localparam logic [ADDR_BIT:0] AemptyLvl = LvlW'(AEMPTY_THRESH);

    if (!params_ok(FIFO_LENGTH, ADDR_BIT, AFULL_THRESH, AEMPTY_THRESH)) begin : g_param_check
        $fatal(1, "syn_fifo_flags: illegal depth or threshold parameters");
    end

    logic [ADDR_BIT:0] wbin_q, wbin_d, rbin_q, rbin_d, level_q, level_d;
    logic full_q, full_d, empty_q, empty_d;
    logic afull_q, afull_d, aempty_q, aempty_d;
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic wr_acc, rd_acc, mem_we;
    logic [DATA_BITS-1:0] mem_rdata;

    always_comb begin
        wr_acc   = write & ~full_q;
        rd_acc   = read & ~empty_q;
        wbin_d   = wbin_q + LvlW'(wr_acc);
        rbin_d   = rbin_q + LvlW'(rd_acc);
        level_d  = level_q + LvlW'(wr_acc) - LvlW'(rd_acc);
        full_d   = (level_d == FullLvl);
        empty_d  = (level_d == '0);
        afull_d  = (level_d >= AfullLvl);
        aempty_d = (level_d <= AemptyLvl);
        // A fresh error in the same cycle as clear_err must survive the clear.
        ovf_d    = (write & full_q) | (ovf_q & ~clear_err);
        unf_d    = (read & empty_q) | (unf_q & ~clear_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wbin_q   <= '0;
            rbin_q   <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            rbin_q   <= rbin_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Writes presented during reset must not land in storage.
    assign mem_we = wr_acc & ~reset;

    syn_fifo_mem #(
        .DataBits (DATA_BITS),
        .Depth    (FIFO_LENGTH),
        .AddrBits (ADDR_BIT)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (wbin_q[ADDR_BIT-1:0]),
        .wdata_i (input_data),
        .raddr_i (rbin_q[ADDR_BIT-1:0]),
        .rdata_o (mem_rdata)
    );

    if (Mode == FIFO_STD) begin : g_std
        logic [DATA_BITS-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = rd_acc ? mem_rdata : dout_q;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign output_data = dout_q;
    end else begin : g_fwft
        assign output_data = mem_rdata;
    end

    // Wrap bits only matter for pointer bookkeeping; level is tracked directly.
    logic unused_ptr_msb;
    assign unused_ptr_msb = wbin_q[ADDR_BIT] ^ rbin_q[ADDR_BIT];

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
